// File: rtl/hsid_pkg.sv
// hsid_pkg: shared HSID widths and state encodings
package hsid_pkg;
    localparam int HSID_DATA_WIDTH        = 16;
    localparam int HSID_DATA_WIDTH_MUL    = 32;
    localparam int HSID_DATA_WIDTH_ACC    = 40;
    localparam int HSID_WORD_WIDTH        = 32;
    localparam int HSID_HSP_BANDS_WIDTH   = 7;
    localparam int HSID_HSP_LIBRARY_WIDTH = 6;

    typedef enum logic [1:0] {HID_IDLE, HID_RUN, HID_DONE} hsid_ite_div_state_t;

    typedef enum logic [2:0] {HMS_IDLE, HMS_ACC, HMS_DRAIN, HMS_DIV, HMS_DONE} hsid_mse_state_t;
endpackage

// File: rtl/hsid_ite_div.sv
// hsid_ite_div: restoring divider producing one quotient bit per cycle
module hsid_ite_div import hsid_pkg::*; #(
    parameter int WIDTH = HSID_DATA_WIDTH_ACC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    hsid_ite_div_state_t state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;
    logic           last;

    assign shifted = {remainder, quotient[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};
    assign fits    = !trial[WIDTH];
    assign last    = cnt == CW'(WIDTH - 1);
    assign done    = state == HID_DONE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HID_IDLE;
        else        state <= state_nxt;
    end

    // next state: clear aborts, start (re)loads, DONE lasts one cycle
    always_comb begin
        state_nxt = state;
        if (clear)                          state_nxt = HID_IDLE;
        else if (start)                     state_nxt = HID_RUN;
        else if (state == HID_RUN && last)  state_nxt = HID_DONE;
        else if (state == HID_DONE)         state_nxt = HID_IDLE;
    end

    // shift-subtract datapath; quotient bits enter from the right as dividend bits leave the left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (start) begin
            cnt       <= '0;
            dvs       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (state == HID_RUN) begin
            cnt       <= cnt + 1'b1;
            quotient  <= {quotient[WIDTH-2:0], fits};
            remainder <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/hsid_mse.sv
// hsid_mse: per-pixel mean squared error over band pairs with iterative division
module hsid_mse import hsid_pkg::*; #(
    parameter int DATA_WIDTH        = HSID_DATA_WIDTH,
    parameter int DATA_WIDTH_MUL    = HSID_DATA_WIDTH_MUL,
    parameter int DATA_WIDTH_ACC    = HSID_DATA_WIDTH_ACC,
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic [HSP_BANDS_WIDTH-1:0]   band_len,
    input  logic [HSP_LIBRARY_WIDTH-1:0] ref_id,
    input  logic                         element_valid,
    output logic                         element_ready,
    input  logic [DATA_WIDTH-1:0]        vctr1,
    input  logic [DATA_WIDTH-1:0]        vctr2,
    output logic                         mse_valid,
    output logic [WORD_WIDTH-1:0]        mse_value,
    output logic [DATA_WIDTH_ACC-1:0]    acc_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] mse_ref_id,
    output logic                         mse_error,
    output logic                         busy
);
    hsid_mse_state_t state, state_nxt;

    logic [HSP_BANDS_WIDTH-1:0]   band_len_q;
    logic [HSP_LIBRARY_WIDTH-1:0] ref_q;
    logic [HSP_BANDS_WIDTH-1:0]   band_cnt;
    logic                         s1_v;
    logic [DATA_WIDTH-1:0]        s1_d;
    logic                         s2_v;
    logic [DATA_WIDTH_MUL-1:0]    s2_sq;
    logic [DATA_WIDTH_ACC-1:0]    acc;
    logic [DATA_WIDTH-1:0]        diff;
    logic                         accept;
    logic                         last_band;
    logic                         start_ok;
    logic                         div_start;
    logic                         div_done;
    logic [DATA_WIDTH_ACC-1:0]    quotient;
    logic [DATA_WIDTH_ACC-1:0]    remainder;

    assign element_ready = state == HMS_ACC;
    assign busy          = state != HMS_IDLE;
    assign mse_valid     = state == HMS_DONE;
    assign accept        = element_valid && element_ready;
    assign last_band     = (band_cnt + 1'b1) == band_len_q;
    assign start_ok      = state == HMS_IDLE && start && band_len != '0;
    assign diff          = vctr1 >= vctr2 ? vctr1 - vctr2 : vctr2 - vctr1;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HMS_IDLE;
        else        state <= state_nxt;
    end

    // control: accumulate band pairs, drain the pipeline, divide, present result
    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        if (clear) begin
            state_nxt = HMS_IDLE;
        end else begin
            case (state)
                HMS_IDLE:  state_nxt = start_ok ? HMS_ACC : HMS_IDLE;
                HMS_ACC:   state_nxt = accept && last_band ? HMS_DRAIN : HMS_ACC;
                HMS_DRAIN: begin
                    div_start = !s1_v && !s2_v;
                    state_nxt = div_start ? HMS_DIV : HMS_DRAIN;
                end
                HMS_DIV:   state_nxt = div_done ? HMS_DONE : HMS_DIV;
                HMS_DONE:  state_nxt = HMS_IDLE;
                default:   state_nxt = HMS_IDLE;
            endcase
        end
    end

    // difference -> square -> accumulate pipeline, band counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band_len_q <= '0;
            ref_q      <= '0;
            band_cnt   <= '0;
            s1_v       <= 1'b0;
            s1_d       <= '0;
            s2_v       <= 1'b0;
            s2_sq      <= '0;
            acc        <= '0;
            mse_error  <= 1'b0;
            mse_value  <= '0;
            acc_value  <= '0;
            mse_ref_id <= '0;
        end else if (clear) begin
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            mse_error  <= 1'b0;
            mse_value  <= '0;
            acc_value  <= '0;
            mse_ref_id <= '0;
        end else begin
            mse_error <= state == HMS_IDLE && start && band_len == '0;
            s1_v      <= accept;
            s2_v      <= s1_v;
            if (accept) s1_d <= diff;
            if (s1_v)   s2_sq <= DATA_WIDTH_MUL'(s1_d) * DATA_WIDTH_MUL'(s1_d);
            if (start_ok) begin
                band_len_q <= band_len;
                ref_q      <= ref_id;
                band_cnt   <= '0;
                acc        <= '0;
                mse_value  <= '0;
                acc_value  <= '0;
                mse_ref_id <= '0;
            end else begin
                if (accept) band_cnt <= band_cnt + 1'b1;
                if (s2_v)   acc <= acc + DATA_WIDTH_ACC'(s2_sq);
            end
            if (state == HMS_DIV && div_done) begin
                mse_value  <= quotient[WORD_WIDTH-1:0];
                acc_value  <= acc;
                mse_ref_id <= ref_q;
            end
        end
    end

    hsid_ite_div #(.WIDTH(DATA_WIDTH_ACC)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .clear     (clear),
        .dividend  (acc),
        .divisor   (DATA_WIDTH_ACC'(band_len_q)),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (div_done)
    );
endmodule
